// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side lookup and EX-side training bundle for the gshare predictor.
interface gshare_branch_predictor_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned GHR_BITS = 5
);
  // Fetch lookup
  logic [XLEN-1:0]     current_pc;
  logic                fetch_en;
  logic [XLEN-1:0]     pc_predict;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_ghr;

  // EX resolution / training
  logic                upd_valid;
  logic [XLEN-1:0]     upd_pc;
  logic                upd_is_branch;
  logic                upd_taken;
  logic [XLEN-1:0]     upd_target;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_mispredict;

  // Pipeline side: drives fetch PC and resolved outcomes, consumes predictions
  modport master (
    output current_pc, fetch_en,
    output upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target, upd_ghr, upd_mispredict,
    input  pc_predict, pred_taken, pred_ghr
  );

  // Predictor side
  modport slave (
    input  current_pc, fetch_en,
    input  upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target, upd_ghr, upd_mispredict,
    output pc_predict, pred_taken, pred_ghr
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with a direct-mapped tagged BTB.
// Lookup is combinational on the fetch PC; training and history repair come from EX.
module gshare_branch_predictor #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BTB_IDX_BITS = 5,
  parameter int unsigned PHT_IDX_BITS = 5,
  parameter int unsigned GHR_BITS     = 5,
  parameter int unsigned CTR_BITS     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  gshare_branch_predictor_if.slave   bus
);

  localparam int unsigned BTB_DEPTH = 1 << BTB_IDX_BITS;
  localparam int unsigned PHT_DEPTH = 1 << PHT_IDX_BITS;
  localparam int unsigned TAG_BITS  = XLEN - BTB_IDX_BITS - 2;

  // Weakly not-taken: MSB clear, all lower bits set
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  logic                    btb_valid  [BTB_DEPTH];
  logic                    btb_uncond [BTB_DEPTH];
  logic [TAG_BITS-1:0]     btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]         btb_target [BTB_DEPTH];
  logic [CTR_BITS-1:0]     pht        [PHT_DEPTH];
  logic [GHR_BITS-1:0]     ghr;
  logic [GHR_BITS-1:0]     ghr_next;

  logic [BTB_IDX_BITS-1:0] bidx;
  logic [PHT_IDX_BITS-1:0] pidx;
  logic [TAG_BITS-1:0]     lookup_tag;
  logic                    lookup_hit;
  logic                    lookup_taken;

  logic [BTB_IDX_BITS-1:0] upd_bidx;
  logic [PHT_IDX_BITS-1:0] upd_pidx;
  logic [TAG_BITS-1:0]     upd_tag;
  logic                    btb_wr;
  logic                    pht_wr;

  logic                    unused_pc_bits;
  assign unused_pc_bits = ^{bus.current_pc[1:0], bus.upd_pc[1:0]};

  // Fetch lookup: history is zero-extended to the PHT index width before hashing
  always_comb begin
    bidx         = bus.current_pc[BTB_IDX_BITS+1:2];
    lookup_tag   = bus.current_pc[XLEN-1:BTB_IDX_BITS+2];
    pidx         = bus.current_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr);
    lookup_hit   = btb_valid[bidx] && (btb_tag[bidx] == lookup_tag);
    lookup_taken = lookup_hit && (btb_uncond[bidx] || pht[pidx][CTR_BITS-1]);
  end

  assign bus.pred_taken = lookup_taken;
  assign bus.pc_predict = lookup_taken ? btb_target[bidx] : bus.current_pc + XLEN'(4);
  assign bus.pred_ghr   = ghr;

  // Training indices, using the history snapshot that was live at prediction time
  always_comb begin
    upd_bidx = bus.upd_pc[BTB_IDX_BITS+1:2];
    upd_tag  = bus.upd_pc[XLEN-1:BTB_IDX_BITS+2];
    upd_pidx = bus.upd_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(bus.upd_ghr);
    btb_wr   = bus.upd_valid && bus.upd_taken;
    pht_wr   = bus.upd_valid && bus.upd_is_branch;
  end

  // Next history: EX repair beats speculative fetch shift; the truncating cast
  // yields {h[GHR_BITS-2:0], bit}, which degenerates to just the bit when GHR_BITS==1
  always_comb begin
    ghr_next = ghr;
    if (bus.upd_valid && bus.upd_mispredict) begin
      if (bus.upd_is_branch || (GHR_BITS == 1)) begin
        ghr_next = GHR_BITS'({bus.upd_ghr, bus.upd_taken});
      end else begin
        ghr_next = bus.upd_ghr;
      end
    end else if (bus.fetch_en && lookup_hit && !btb_uncond[bidx]) begin
      ghr_next = GHR_BITS'({ghr, lookup_taken});
    end
  end

  // Global history register
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

  // Saturating direction counters
  always_ff @(posedge clk) begin
    if (reset) begin
      pht <= '{default: CTR_INIT};
    end else if (pht_wr) begin
      if (bus.upd_taken) begin
        if (pht[upd_pidx] != CTR_MAX) begin
          pht[upd_pidx] <= pht[upd_pidx] + CTR_BITS'(1);
        end
      end else if (pht[upd_pidx] != '0) begin
        pht[upd_pidx] <= pht[upd_pidx] - CTR_BITS'(1);
      end
    end
  end

  // BTB control bits; only taken outcomes allocate or replace an entry
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid  <= '{default: 1'b0};
      btb_uncond <= '{default: 1'b0};
    end else if (btb_wr) begin
      btb_valid[upd_bidx]  <= 1'b1;
      btb_uncond[upd_bidx] <= !bus.upd_is_branch;
    end
  end

  // BTB payload; contents are qualified by the valid bit so no reset is needed
  always_ff @(posedge clk) begin
    if (!reset && btb_wr) begin
      btb_tag[upd_bidx]    <= upd_tag;
      btb_target[upd_bidx] <= bus.upd_target;
    end
  end

endmodule
